bounce_engine: RTL and testbench
================================

BOUNCE_ENGINE -- requirements
Module: bounce_engine

Interface
REQ-001 Parameter N_SPR, default 4, number of sprites (legal range 1..8).
REQ-002 Parameter SIZE, default 32, sprite edge length in pixels (square).
REQ-003 Parameters H_RES / V_RES, default 640 / 480, visible area.
REQ-004 Parameter COLORS, 48 bits, 6 bits per sprite; sprite i colour = COLORS[6i+5:6i].
  - Default colours, sprites 0..7: 110000, 001100, 000011, 111100, 110011, 001111, 111111, 101010.
REQ-005 clk  in  1  pixel clock, sole clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 frame_start  in  1  single-cycle pulse, once per frame, during vertical blank.
REQ-008 pause  in  1  1 = positions frozen.
REQ-009 speed_sel  in  2  step multiplier, base step << speed_sel.
REQ-010 hpos / vpos  in  10 each  current pixel coordinate.
REQ-011 display_on  in  1  visible-area qualifier.
REQ-012 rgb  out  6  {R1,R0,G1,G0,B1,B0}, registered.
REQ-013 busy  out  1  high while the position update runs.
REQ-014 collide  out  N_SPR  sticky per-frame overlap flags.
REQ-015 frame_cnt  out  8  accepted-frame counter.

Function
REQ-016 Per sprite state: x (10b), y (10b), dx (1 = +), dy (1 = +).
REQ-017 Base steps: sx_i = (i mod 4) + 1, sy_i = ((i+1) mod 4) + 1.
  - Applied step = base << speed_sel, computed at 11 bits, no truncation.
REQ-018 FSM has two states, IDLE and UPD; a 3-bit index counter runs in UPD.
  - IDLE -> UPD on accepted frame_start; index = 0.
  - UPD steps sprite[index], one sprite per cycle.
  - UPD -> IDLE after sprite N_SPR-1 is stepped.
REQ-019 Latency: frame_start sampled at edge t updates sprite i at edge t+1+i; busy = 1 for edges t+1..t+N_SPR.
REQ-020 frame_start while busy = 1 is ignored entirely: no clear, no count, no restart.
REQ-021 Accepted frame_start clears collide and increments frame_cnt (wrap 255 -> 0), including when pause = 1.
REQ-022 When pause = 1 at acceptance, the FSM stays in IDLE and no position changes.
REQ-023 X step rule (Y is identical, using V_RES, sy, dy):
  - dx = 1 and x + step >= H_RES - SIZE: x <= H_RES - SIZE, dx <= 0.
  - dx = 0 and x <= step: x <= 0, dx <= 1.
  - Otherwise x <= x +/- step.
REQ-024 Hit rule: hit_i = display_on and x_i <= hpos < x_i + SIZE and y_i <= vpos < y_i + SIZE.
  - Bounds are evaluated at 11 bits.
REQ-025 rgb at edge t+1 takes the colour of the lowest-index sprite hit at t; 000000 if no hit or display_on = 0.
REQ-026 collide[i] sets at the edge after any pixel where hit_i and at least one other hit_j are both true.
  - An accepted frame_start on the same edge as a set wins; collide is cleared.
REQ-027 Position and direction registers change only in UPD.

Reset
REQ-028 rst_n low asynchronously forces, per sprite:
  - x_i = 24*i, y_i = 16*i.
  - dx_i = 1 for even i, 0 for odd i.
  - dy_i = 1 for i < 2, else 0.
REQ-029 Reset values of the remaining state and outputs:
  - FSM = IDLE, index = 0, busy = 0.
  - rgb = 0, collide = 0, frame_cnt = 0.
REQ-030 Reset asserted mid-UPD abandons the update; after release no partial-update value remains, and the first frame_start restarts at sprite 0.

Verification (N_SPR=4, SIZE=32, speed_sel=0 unless stated)
REQ-031 Reset, one frame_start -> busy high for 4 cycles; sprite0 = (1,2); sprite1 = (22,19); frame_cnt = 1.
REQ-032 12 frames -> sprite1 x = 0 with dx flipped to 1; frame 13 -> x = 2.
REQ-033 After reset, drive display_on=1 at (28,20) -> next cycle rgb = 110000, collide = 0011; next frame_start -> collide = 0000.
REQ-034 speed_sel=3, one frame -> sprite0 = (8,16); pause=1 plus 5 frames -> positions unchanged, frame_cnt +5.
REQ-035 Second frame_start during busy -> ignored, frame_cnt +1 only; rst_n pulse mid-UPD -> all reset values.

Source files
------------

// File: rtl/bounce_engine.sv
// Bouncing-sprite engine: steps N_SPR square sprites once per frame and
// renders a registered 6-bit pixel colour plus sticky per-frame overlap flags.
module bounce_engine #(
    parameter int          N_SPR  = 4,
    parameter int          SIZE   = 32,
    parameter int          H_RES  = 640,
    parameter int          V_RES  = 480,
    parameter logic [47:0] COLORS = {6'b101010, 6'b111111, 6'b001111, 6'b110011,
                                     6'b111100, 6'b000011, 6'b001100, 6'b110000}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             pause,
    input  logic [1:0]       speed_sel,
    input  logic [9:0]       hpos,
    input  logic [9:0]       vpos,
    input  logic             display_on,
    output logic [5:0]       rgb,
    output logic             busy,
    output logic [N_SPR-1:0] collide,
    output logic [7:0]       frame_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        UPD  = 1'b1
    } state_t;

    localparam logic [10:0] X_LIM = 11'(H_RES - SIZE);
    localparam logic [10:0] Y_LIM = 11'(V_RES - SIZE);
    localparam logic [10:0] SZ    = 11'(SIZE);
    localparam logic [2:0]  LAST  = 3'(N_SPR - 1);

    // Result is {new_dir, new_pos}; the comparison runs at 11 bits so pos + step cannot wrap.
    function automatic logic [10:0] axis_step(
        input logic [9:0]  pos,
        input logic        dir,
        input logic [10:0] step,
        input logic [10:0] lim
    );
        logic [10:0] p;
        logic [10:0] res;
        p = {1'b0, pos};
        if (dir) begin
            if ((p + step) >= lim) begin
                res = {1'b0, lim[9:0]};
            end else begin
                res = {1'b1, 10'(p + step)};
            end
        end else begin
            if (p <= step) begin
                res = {1'b1, 10'd0};
            end else begin
                res = {1'b0, 10'(p - step)};
            end
        end
        return res;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [5:0]       rgb_q, rgb_d;
    logic [N_SPR-1:0] collide_q, collide_d;
    logic [9:0]       x_q [N_SPR];
    logic [9:0]       x_d [N_SPR];
    logic [9:0]       y_q [N_SPR];
    logic [9:0]       y_d [N_SPR];
    logic [N_SPR-1:0] dx_q, dx_d;
    logic [N_SPR-1:0] dy_q, dy_d;

    logic             accept_s;
    logic [N_SPR-1:0] hit_s;
    logic [N_SPR-1:0] others_s;
    logic [10:0]      step_x_s, step_y_s;
    logic [10:0]      nx_s, ny_s;

    // A frame_start arriving while an update is in flight is dropped completely.
    assign accept_s = frame_start && !busy_q;

    // Control FSM next state, update index and frame counter.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        frame_cnt_d = accept_s ? (frame_cnt_q + 8'd1) : frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s && !pause) begin
                    state_d = UPD;
                    idx_d   = 3'd0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                    busy_d  = 1'b0;
                end
            end
            UPD: begin
                if (idx_q == LAST) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = UPD;
                    idx_d   = idx_q + 3'd1;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sprite position/direction next state; only the indexed sprite moves, only in UPD.
    always_comb begin
        step_x_s = 11'd0;
        step_y_s = 11'd0;
        nx_s     = 11'd0;
        ny_s     = 11'd0;
        dx_d     = dx_q;
        dy_d     = dy_q;
        for (int i = 0; i < N_SPR; i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
            if ((state_q == UPD) && (idx_q == 3'(i))) begin
                step_x_s = 11'((i % 4) + 1) << speed_sel;
                step_y_s = 11'(((i + 1) % 4) + 1) << speed_sel;
                nx_s     = axis_step(x_q[i], dx_q[i], step_x_s, X_LIM);
                ny_s     = axis_step(y_q[i], dy_q[i], step_y_s, Y_LIM);
                x_d[i]   = nx_s[9:0];
                dx_d[i]  = nx_s[10];
                y_d[i]   = ny_s[9:0];
                dy_d[i]  = ny_s[10];
            end else begin
                x_d[i]   = x_q[i];
                y_d[i]   = y_q[i];
                dx_d[i]  = dx_q[i];
                dy_d[i]  = dy_q[i];
            end
        end
    end

    // Pixel hit test, priority colour select and collision flag next state.
    always_comb begin
        hit_s    = {N_SPR{1'b0}};
        others_s = {N_SPR{1'b0}};
        for (int i = 0; i < N_SPR; i++) begin
            hit_s[i] = display_on
                    && ({1'b0, hpos} >= {1'b0, x_q[i]})
                    && ({1'b0, hpos} <  ({1'b0, x_q[i]} + SZ))
                    && ({1'b0, vpos} >= {1'b0, y_q[i]})
                    && ({1'b0, vpos} <  ({1'b0, y_q[i]} + SZ));
        end
        rgb_d = 6'b000000;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            rgb_d = hit_s[i] ? COLORS[6*i +: 6] : rgb_d;
        end
        collide_d = collide_q;
        if (accept_s) begin
            collide_d = {N_SPR{1'b0}};
        end else begin
            for (int i = 0; i < N_SPR; i++) begin
                others_s     = hit_s;
                others_s[i]  = 1'b0;
                collide_d[i] = collide_q[i] | (hit_s[i] & (|others_s));
            end
        end
    end

    // State registers; reset scatters the sprites diagonally with mixed directions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 8'd0;
            rgb_q       <= 6'b000000;
            collide_q   <= {N_SPR{1'b0}};
            for (int i = 0; i < N_SPR; i++) begin
                x_q[i]  <= 10'(24 * i);
                y_q[i]  <= 10'(16 * i);
                dx_q[i] <= ((i % 2) == 0);
                dy_q[i] <= (i < 2);
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            rgb_q       <= rgb_d;
            collide_q   <= collide_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            for (int i = 0; i < N_SPR; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign rgb       = rgb_q;
    assign busy      = busy_q;
    assign collide   = collide_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_bounce_engine.sv
// Directed bench for bounce_engine (N_SPR=4, SIZE=32): movement, bounce,
// rendering, collision, pause, busy-drop, mid-update reset and counter wrap.
module tb_bounce_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       pause;
    logic [1:0] speed_sel;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic [5:0] rgb;
    logic       busy;
    logic [3:0] collide;
    logic [7:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    bounce_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pause       (pause),
        .speed_sel   (speed_sel),
        .hpos        (hpos),
        .vpos        (vpos),
        .display_on  (display_on),
        .rgb         (rgb),
        .busy        (busy),
        .collide     (collide),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_spr(input string tag, input int i, input int ex, input int ey,
                           input logic edx, input logic edy);
        chk({tag, "_x"},  32'(dut.x_q[i]),  32'(ex));
        chk({tag, "_y"},  32'(dut.y_q[i]),  32'(ey));
        chk({tag, "_dx"}, 32'(dut.dx_q[i]), 32'(edx));
        chk({tag, "_dy"}, 32'(dut.dy_q[i]), 32'(edy));
    endtask

    task automatic chk_reset_state(input string tag);
        chk_spr({tag, "_s0"}, 0, 0,  0,  1'b1, 1'b1);
        chk_spr({tag, "_s1"}, 1, 24, 16, 1'b0, 1'b1);
        chk_spr({tag, "_s2"}, 2, 48, 32, 1'b1, 1'b0);
        chk_spr({tag, "_s3"}, 3, 72, 48, 1'b0, 1'b0);
        chk({tag, "_busy"},    32'(busy),      32'd0);
        chk({tag, "_rgb"},     32'(rgb),       32'd0);
        chk({tag, "_collide"}, 32'(collide),   32'd0);
        chk({tag, "_fcnt"},    32'(frame_cnt), 32'd0);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (4) tick();
    endtask

    task automatic frame_p();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        pause       = 1'b0;
        speed_sel   = 2'd0;
        hpos        = 10'd1000;
        vpos        = 10'd1000;
        display_on  = 1'b0;
        repeat (3) tick();
        chk_reset_state("rst");
        rst_n = 1'b1;
        tick();

        // Rendering and collisions at the reset positions
        display_on = 1'b1; hpos = 10'd28; vpos = 10'd20;
        tick();
        chk("rgb_overlap", 32'(rgb), 32'(6'b110000));
        chk("collide_set", 32'(collide), 32'(4'b0011));
        hpos = 10'd32;
        tick();
        chk("rgb_s0_right_edge", 32'(rgb), 32'(6'b001100));
        hpos = 10'd23;
        tick();
        chk("rgb_s1_left_edge", 32'(rgb), 32'(6'b110000));
        hpos = 10'd700;
        tick();
        chk("rgb_no_hit", 32'(rgb), 32'd0);
        display_on = 1'b0; hpos = 10'd28;
        tick();
        chk("rgb_blank", 32'(rgb), 32'd0);
        chk("collide_sticky", 32'(collide), 32'(4'b0011));

        // First frame: clear, count and busy window
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("collide_clr", 32'(collide), 32'd0);
        chk("fcnt_1", 32'(frame_cnt), 32'd1);
        chk("busy_t0", 32'(busy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("busy_mid", 32'(busy), 32'd1);
        end
        tick();
        chk("busy_end", 32'(busy), 32'd0);
        chk_spr("f1_s0", 0, 1,  2,  1'b1, 1'b1);
        chk_spr("f1_s1", 1, 22, 19, 1'b0, 1'b1);
        chk_spr("f1_s2", 2, 51, 28, 1'b1, 1'b0);
        chk_spr("f1_s3", 3, 68, 47, 1'b0, 1'b0);

        // Left-wall bounce of sprite 1
        repeat (11) frame();
        chk_spr("f12_s1", 1, 0, 52, 1'b1, 1'b1);
        chk("fcnt_12", 32'(frame_cnt), 32'd12);
        frame();
        chk_spr("f13_s1", 1, 2, 55, 1'b1, 1'b1);
        chk_spr("f13_s0", 0, 13, 26, 1'b1, 1'b1);

        // frame_start during busy is dropped
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (2) tick();
        chk("busy_no_restart", 32'(busy), 32'd0);
        chk("fcnt_drop", 32'(frame_cnt), 32'd14);
        chk_spr("f14_s0", 0, 14, 28, 1'b1, 1'b1);

        // speed_sel = 3 then paused frames
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        speed_sel = 2'd3;
        frame();
        chk_spr("fast_s0", 0, 8, 16, 1'b1, 1'b1);
        chk_spr("fast_s1", 1, 8, 40, 1'b0, 1'b1);
        chk("fcnt_fast", 32'(frame_cnt), 32'd1);
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            chk("busy_paused", 32'(busy), 32'd0);
            tick();
        end
        chk_spr("pause_s0", 0, 8, 16, 1'b1, 1'b1);
        chk_spr("pause_s1", 1, 8, 40, 1'b0, 1'b1);
        chk("fcnt_pause", 32'(frame_cnt), 32'd6);

        // Reset in the middle of an update
        pause = 1'b0;
        speed_sel = 2'd0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("busy_after_rst", 32'(busy), 32'd1);
        repeat (4) tick();
        chk_spr("restart_s0", 0, 1,  2,  1'b1, 1'b1);
        chk_spr("restart_s1", 1, 22, 19, 1'b0, 1'b1);
        chk_spr("restart_s3", 3, 68, 47, 1'b0, 1'b0);
        chk("fcnt_restart", 32'(frame_cnt), 32'd1);

        // Frame counter wrap 255 -> 0
        pause = 1'b1;
        repeat (255) frame_p();
        chk("fcnt_wrap", 32'(frame_cnt), 32'd0);
        frame_p();
        chk("fcnt_after_wrap", 32'(frame_cnt), 32'd1);
        chk_spr("wrap_s0", 0, 1, 2, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
